// File: rtl/i2c_slave.sv
// i2c_slave: I2C/SCCB target bridging SCL/SDA to a register bank; 7-bit address match,
// register pointer byte, then byte writes or reads with pointer auto-increment.
module i2c_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h21,
    parameter int         REG_AW   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SCL,
    inout  wire               SDA,
    output logic [REG_AW-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              addr_hit
);
    typedef enum logic [3:0] {
        IDLE, ADDR, IGNORE, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          scl_q, sda_q;
    logic [3:0]          cnt_q, cnt_d;
    logic [7:0]          sh_q, sh_d, tx_q, tx_d, wdata_q, wdata_d;
    logic [REG_AW-1:0]   ptr_q, ptr_d;
    logic                wr_q, wr_d, hit_q, hit_d, oe_q, oe_d, rw_q, rw_d, ph_q, ph_d;
    logic                rise, fall, start, stop, bit_in, last, load;
    logic [7:0]          byte_in;

    // [1] is the synchronized level, [2] its one-cycle history
    assign rise    = scl_q[1] & ~scl_q[2];
    assign fall    = ~scl_q[1] & scl_q[2];
    assign start   = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop    = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    assign bit_in  = sda_q[1];
    assign byte_in = {sh_q[6:0], bit_in};
    assign last    = cnt_q == 4'd7;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            scl_q   <= '1;
            sda_q   <= '1;
            cnt_q   <= '0;
            sh_q    <= '0;
            tx_q    <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
            wr_q    <= 1'b0;
            hit_q   <= 1'b0;
            oe_q    <= 1'b0;
            rw_q    <= 1'b0;
            ph_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            scl_q   <= {scl_q[1:0], SCL};
            sda_q   <= {sda_q[1:0], SDA};
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            hit_q   <= hit_d;
            oe_q    <= oe_d;
            rw_q    <= rw_d;
            ph_q    <= ph_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        wdata_d = wdata_q;
        ptr_d   = ptr_q;
        wr_d    = 1'b0;
        hit_d   = 1'b0;
        oe_d    = oe_q;
        rw_d    = rw_q;
        ph_d    = ph_q;
        load    = 1'b0;
        if (start) begin
            state_d = ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
            ph_d    = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            ph_d    = 1'b0;
        end else begin
            if (rise && (state_q == ADDR || state_q == REG || state_q == WDATA || state_q == RDATA)) begin
                sh_d  = byte_in;
                cnt_d = last ? 4'd0 : cnt_q + 4'd1;
            end
            case (state_q)
                ADDR: if (rise && last) begin
                    state_d = byte_in[7:1] == DEV_ADDR ? ADDR_ACK : IGNORE;
                    hit_d   = byte_in[7:1] == DEV_ADDR;
                    rw_d    = byte_in[0];
                end
                REG: if (rise && last) begin
                    ptr_d   = REG_AW'(byte_in);
                    state_d = REG_ACK;
                end
                WDATA: if (rise && last) begin
                    wdata_d = byte_in;
                    wr_d    = 1'b1;
                    state_d = WDATA_ACK;
                end
                // ph_q: 0 = waiting to start driving ACK, 1 = ACK on the bus
                ADDR_ACK, REG_ACK, WDATA_ACK: if (fall) begin
                    ph_d = ~ph_q;
                    oe_d = ~ph_q;
                    if (ph_q) begin
                        state_d = state_q == REG_ACK ? WDATA : state_q == WDATA_ACK ? WDATA : rw_q ? RDATA : REG;
                        ptr_d   = state_q == WDATA_ACK ? ptr_q + REG_AW'(1) : ptr_q;
                        load    = state_q == ADDR_ACK && rw_q;
                    end
                end
                RDATA: begin
                    if (fall) begin
                        tx_d = {tx_q[6:0], 1'b0};
                        oe_d = ~tx_q[6];
                    end
                    if (rise && last) state_d = RDATA_ACK;
                end
                // ph_q: master ACK seen, reload on the next fall
                RDATA_ACK: begin
                    if (rise) begin
                        ph_d    = ~bit_in;
                        ptr_d   = bit_in ? ptr_q : ptr_q + REG_AW'(1);
                        state_d = bit_in ? IGNORE : RDATA_ACK;
                    end
                    if (fall) begin
                        oe_d    = 1'b0;
                        load    = ph_q;
                        ph_d    = 1'b0;
                        state_d = ph_q ? RDATA : RDATA_ACK;
                    end
                end
                default: oe_d = 1'b0;
            endcase
            if (load) begin
                tx_d  = reg_rdata;
                oe_d  = ~reg_rdata[7];
                cnt_d = '0;
            end
        end
    end

    assign SDA       = oe_q ? 1'b0 : 1'bz;
    assign reg_addr  = ptr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr    = wr_q;
    assign addr_hit  = hit_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master with a register-bank model driving i2c_slave
// through write, repeated-start read, mismatch, wrap and abort sequences.
module tb_i2c_slave;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    wire        sda_w;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_wr, busy, addr_hit;
    logic [7:0] bank [256];
    logic [15:0] wq [$];
    int         hits = 0;
    int         total = 0, passed = 0, fails = 0;
    logic       ack;
    logic [7:0] rb;

    pullup (sda_w);
    assign sda_w = m_sda ? 1'bz : 1'b0;
    assign reg_rdata = bank[reg_addr];

    always #5 clk = ~clk;

    i2c_slave dut (
        .clk(clk), .reset(reset), .SCL(scl), .SDA(sda_w),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr),
        .reg_rdata(reg_rdata), .busy(busy), .addr_hit(addr_hit)
    );

    always @(posedge clk) begin
        if (reg_wr) begin
            wq.push_back({reg_addr, reg_wdata});
            bank[reg_addr] <= reg_wdata;
        end
        if (addr_hit) hits++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wq_t();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; scl = 1'b1; wq_t();
        m_sda = 1'b0; wq_t();
        scl = 1'b0; wq_t();
    endtask

    task automatic i2c_rstart();
        m_sda = 1'b1; wq_t();
        scl = 1'b1; wq_t();
        m_sda = 1'b0; wq_t();
        scl = 1'b0; wq_t();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wq_t();
        scl = 1'b1; wq_t();
        m_sda = 1'b1; wq_t();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; wq_t();
        scl = 1'b1; wq_t(); wq_t();
        scl = 1'b0; wq_t();
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; wq_t();
        scl = 1'b1; wq_t();
        b = sda_w; wq_t();
        scl = 1'b0; wq_t();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic a);
        for (int i = 7; i >= 0; i--) recv_bit(d[i]);
        send_bit(a);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) bank[i] = 8'h00;
        bank[8'h20] = 8'h3C;
        bank[8'h21] = 8'hC3;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_addr", 16'(reg_addr), 16'h00);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_wr", 16'(reg_wr), 16'h0);
        chk("rst_hit", 16'(addr_hit), 16'h0);
        chk("rst_sda", 16'(sda_w), 16'h1);

        i2c_start();
        chk("wr_busy", 16'(busy), 16'h1);
        write_byte(8'h42, ack); chk("wr_ack_dev", 16'(ack), 16'h0);
        chk("wr_hits", 16'(hits), 16'd1);
        write_byte(8'h10, ack); chk("wr_ack_reg", 16'(ack), 16'h0);
        write_byte(8'hA5, ack); chk("wr_ack_d0", 16'(ack), 16'h0);
        write_byte(8'h5A, ack); chk("wr_ack_d1", 16'(ack), 16'h0);
        i2c_stop();
        wq_t();
        chk("wr_busy_stop", 16'(busy), 16'h0);
        chk("wr_count", 16'(wq.size()), 16'd2);
        chk("wr_0", wq[0], 16'h10A5);
        chk("wr_1", wq[1], 16'h115A);
        chk("wr_ptr", 16'(reg_addr), 16'h12);

        i2c_start();
        write_byte(8'h42, ack); chk("rd_ack_dev", 16'(ack), 16'h0);
        write_byte(8'h20, ack); chk("rd_ack_reg", 16'(ack), 16'h0);
        i2c_rstart();
        write_byte(8'h43, ack); chk("rd_ack_devr", 16'(ack), 16'h0);
        read_byte(rb, 1'b0); chk("rd_b0", 16'(rb), 16'h3C);
        read_byte(rb, 1'b1); chk("rd_b1", 16'(rb), 16'hC3);
        m_sda = 1'b1; wq_t();
        chk("rd_sda_rel", 16'(sda_w), 16'h1);
        i2c_stop();
        chk("rd_no_wr", 16'(wq.size()), 16'd2);
        chk("rd_ptr", 16'(reg_addr), 16'h21);
        chk("rd_hits", 16'(hits), 16'd3);

        i2c_start();
        write_byte(8'h44, ack); chk("mm_ack_dev", 16'(ack), 16'h1);
        write_byte(8'h10, ack); chk("mm_ack_reg", 16'(ack), 16'h1);
        write_byte(8'hFF, ack); chk("mm_ack_d", 16'(ack), 16'h1);
        i2c_stop();
        chk("mm_no_wr", 16'(wq.size()), 16'd2);
        chk("mm_hits", 16'(hits), 16'd3);

        i2c_start();
        write_byte(8'h42, ack);
        write_byte(8'hFF, ack);
        write_byte(8'h01, ack); chk("wrap_ack0", 16'(ack), 16'h0);
        write_byte(8'h02, ack); chk("wrap_ack1", 16'(ack), 16'h0);
        i2c_stop();
        chk("wrap_count", 16'(wq.size()), 16'd4);
        chk("wrap_0", wq[2], 16'hFF01);
        chk("wrap_1", wq[3], 16'h0002);
        chk("wrap_ptr", 16'(reg_addr), 16'h01);

        i2c_start();
        write_byte(8'h42, ack);
        write_byte(8'h30, ack);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_stop();
        chk("abort_no_wr", 16'(wq.size()), 16'd4);
        chk("abort_ptr", 16'(reg_addr), 16'h30);
        i2c_start();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        #3 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_sda = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_sda", 16'(sda_w), 16'h1);
        chk("abort_busy", 16'(busy), 16'h0);
        chk("abort_ptr_rst", 16'(reg_addr), 16'h00);
        scl = 1'b1; wq_t();

        i2c_start();
        write_byte(8'h42, ack); chk("post_ack", 16'(ack), 16'h0);
        write_byte(8'h05, ack);
        write_byte(8'h77, ack);
        i2c_stop();
        chk("post_count", 16'(wq.size()), 16'd5);
        chk("post_wr", wq[4], 16'h0577);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C/SCCB target (responder) for the on-chip register bank. Bench counterpart and loopback partner of the team's I2C master.
- Decodes START/STOP, matches a 7-bit device address, and takes a register pointer byte. It then writes data bytes to the bank or returns bytes from it, auto-incrementing the pointer.
- Sits between the external SCL/SDA pins and the register bank. SCL is an input only; no clock stretching.

Parameters:
- DEV_ADDR, 7'h21, 7-bit device address this target answers to.
- REG_AW, 8, width of the register pointer and reg_addr.

Ports:
- clk input 1 system clock
- reset input 1 asynchronous, active-high
- SCL input 1 I2C clock from the master
- SDA inout 1 I2C data, open-drain: drives 0 or releases to Z, never drives 1
- reg_addr output REG_AW current register pointer
- reg_wdata output 8 byte received for write
- reg_wr output 1 one-cycle write strobe
- reg_rdata input 8 bank data at reg_addr; combinational, valid 1 clk after reg_addr changes
- busy output 1 high from START to STOP or IDLE
- addr_hit output 1 one-cycle pulse on device-address match (ACKed)

Behaviour:
- Reset values: all outputs 0, SDA released (Z), state IDLE, pointer 0, synchronizers loaded with 1.
- Input conditioning:
  - SCL and SDA each pass through a 2-FF synchronizer plus one history FF.
  - Detection runs on synchronized values only: scl_rise, scl_fall, START (SDA falls while SCL=1), STOP (SDA rises while SCL=1).
  - Detection latency is 3 clk.
- Global rules:
  - START in any state → ADDR, bit counter cleared, SDA released.
  - STOP in any state → IDLE, SDA released, busy=0.
  - START and STOP have priority over bit sampling in the same cycle.
- Bit timing:
  - Sample SDA on scl_rise; MSB first.
  - Change the driven SDA only on scl_fall.
- States:
  - IDLE: SDA released; waits for START.
  - ADDR:
    - Shift 8 bits. After the 8th scl_rise, compare [7:1] with DEV_ADDR.
    - Match → ADDR_ACK and pulse addr_hit. The RW bit is latched.
    - Mismatch → IGNORE.
  - IGNORE: SDA released; waits for START or STOP.
  - ADDR_ACK:
    - Drive SDA=0 from the next scl_fall until the following scl_fall.
    - RW=0 → REG. RW=1 → load tx_shift from reg_rdata, then RDATA.
  - REG: shift 8 bits into the pointer (reg_addr updates at the 8th scl_rise) → REG_ACK (ACK as above) → WDATA.
  - WDATA:
    - Shift 8 bits, then enter WDATA_ACK.
    - On entry to WDATA_ACK: reg_wdata = byte, reg_wr=1 for exactly one clk.
    - At the ACK-ending scl_fall: pointer+1, return to WDATA.
  - RDATA:
    - Drive SDA=0 when tx_shift[7]=0, else release. Shift on each scl_fall after the first bit.
    - After 8 bits → RDATA_ACK with SDA released.
  - RDATA_ACK:
    - Sample the master's ACK on scl_rise.
    - ACK(0): pointer+1; reload tx_shift from reg_rdata (the pointer updates on that scl_rise, reload happens ≥2 clk later, before scl_fall) → RDATA.
    - NACK(1) → IGNORE until STOP or START.
- Pointer arithmetic: REG_AW-bit modulo; 0xFF+1 wraps to 0x00.
- Pointer persistence:
  - The pointer survives STOP and repeated START, so a write of the pointer only followed by a read starts at that pointer.
  - Reset clears it.
- Repeated START mid-byte: partial byte is discarded; no reg_wr issued.
- STOP after REG_ACK with no data: no write; pointer keeps the new value.
- Reset mid-transfer: immediate return to IDLE with SDA released. Bus activity resumes only at the next START.
- Minimum SCL high or low time supported: 4 clk. The master's 250-clk quarter period gives ample margin.

Test Plan:
- Write: START, 0x42(21,W), 0x10, 0xA5, 0x5A, STOP → ACK on all 4 bytes; reg_wr pulses with (0x10,0xA5) then (0x11,0x5A); final reg_addr=0x12; busy drops on STOP.
- Read with repeated START: bank[0x20]=0x3C, bank[0x21]=0xC3. START 0x42, 0x20, RSTART 0x43, master ACK, then NACK, STOP → master receives 0x3C, 0xC3; SDA released after NACK; no reg_wr.
- Address mismatch: START 0x44, 0x10, 0xFF, STOP → all ACK slots read 1 (SDA never driven); no reg_wr; addr_hit stays 0.
- Pointer wrap: START 0x42, 0xFF, 0x01, 0x02, STOP → writes to 0xFF then 0x00.
- Abort: STOP injected after 4 data bits of a write byte, then reset asserted mid-ADDR of the next transfer → no reg_wr for the partial byte; after reset, SDA=Z, busy=0, reg_addr=0.
- Loopback with the team's I2C master (length=1 write, then read, addr 7'h21) → master tx_done/rx_done pulse; rx_data equals the written byte.
